keccak_cmd_master: RTL and testbench

Host-side initiator for the `keccak_top` 32-bit command/data stream. It accepts one hash request, then emits the header word, the length word and the message words on `keccak_top`'s `din` port. It then collects the digest words from `keccak_top`'s `dout` port and forwards them to the host with a last-word marker. It sits between the sampler/controller logic and `keccak_top`, and replaces the hand-written stimulus sequencing used in bring-up.

---
 rtl/keccak_cmd_master.sv | 104 ++++++++++
 tb/tb_keccak_cmd_master.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_cmd_master.sv
// keccak_cmd_master: sequences one hash request into keccak_top (header, length, message) and forwards the digest words to the host
module keccak_cmd_master #(
  parameter int MAX_IN_BITS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [15:0] req_outlen,
  input  logic [15:0] req_inlen,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_data,
  output logic        din_valid,
  input  logic        din_ready,
  output logic [31:0] din,
  input  logic        dout_valid,
  output logic        dout_ready,
  input  logic [31:0] dout,
  output logic        force_done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_last,
  input  logic        abort,
  output logic        busy,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, RESP, ABRT} state_t;
  state_t state;
  logic mode;
  logic [15:0] outlen, inlen;
  logic [10:0] in_cnt, out_cnt;
  logic rejected;
  assign rejected = (req_outlen == 16'd0) || (32'(req_inlen) > MAX_IN_BITS);
  // req_ready is held off while the last digest word drains and during the err pulse
  always_comb begin
    busy       = state != IDLE;
    req_ready  = (state == IDLE) && !res_valid && !err && !rst;
    din_valid  = (state == HDR) || (state == LEN) || ((state == DATA) && msg_valid);
    din        = (state == HDR)  ? {1'b0, mode, 14'b0, outlen} :
                 (state == LEN)  ? {1'b1, 15'b0, inlen} :
                 (state == DATA) ? msg_data : 32'd0;
    msg_ready  = (state == DATA) && din_ready;
    dout_ready = (state == RESP) && (!res_valid || res_ready);
    force_done = state == ABRT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= 1'b0;
      outlen    <= 16'd0;
      inlen     <= 16'd0;
      in_cnt    <= 11'd0;
      out_cnt   <= 11'd0;
      res_valid <= 1'b0;
      res_data  <= 32'd0;
      res_last  <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
        res_last  <= 1'b0;
      end
      if (state != IDLE && abort) begin
        state     <= ABRT;
        res_valid <= 1'b0;
        res_last  <= 1'b0;
        in_cnt    <= 11'd0;
        out_cnt   <= 11'd0;
      end else begin
        case (state)
          IDLE: if (req_valid && req_ready) begin
            if (rejected) err <= 1'b1;
            else begin
              state   <= HDR;
              mode    <= req_mode;
              outlen  <= req_outlen;
              inlen   <= req_inlen;
              in_cnt  <= 11'((17'(req_inlen) + 17'd31) >> 5);
              out_cnt <= 11'((17'(req_outlen) + 17'd31) >> 5);
            end
          end
          HDR: if (din_ready) state <= LEN;
          LEN: if (din_ready) state <= (in_cnt == 11'd0) ? RESP : DATA;
          DATA: if (msg_valid && din_ready) begin
            in_cnt <= in_cnt - 11'd1;
            if (in_cnt == 11'd1) state <= RESP;
          end
          RESP: if (dout_valid && dout_ready) begin
            res_data  <= dout;
            res_valid <= 1'b1;
            res_last  <= out_cnt == 11'd1;
            out_cnt   <= out_cnt - 11'd1;
            if (out_cnt == 11'd1) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keccak_cmd_master.sv
// tb_keccak_cmd_master: directed vector table plus hand sequences for stalls, abort and reset
module tb_keccak_cmd_master;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, req_mode = 1'b0;
  logic [15:0] req_outlen = 16'd0, req_inlen = 16'd0;
  logic msg_valid = 1'b1, msg_ready;
  logic [31:0] msg_data = 32'd0;
  logic din_valid, din_ready = 1'b1;
  logic [31:0] din;
  logic dout_valid = 1'b1, dout_ready;
  logic [31:0] dout = 32'hD000_0000;
  logic force_done, res_valid, res_ready = 1'b1, res_last, abort = 1'b0, busy, err;
  logic [31:0] res_data;

  keccak_cmd_master #(.MAX_IN_BITS(1024)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_outlen(req_outlen), .req_inlen(req_inlen), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout), .force_done(force_done),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .abort(abort), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic mode;
    logic [15:0] outlen, inlen;
    logic [31:0] hdr, len;
    int nin, nout;
    logic err;
  } vec_t;
  vec_t vecs[7];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, msg_idx = 0, dout_idx = 0, msg_start = 0, dout_base = 0;
  int din_start, res_start, dout_start, msg_rdy0, force0, fall_cyc;
  int msg_rdy_cnt = 0, force_cnt = 0, rr_viol = 0, stab_viol = 0;
  logic toggle = 1'b0, pend = 1'b0;
  logic [31:0] pend_din = 32'd0;
  logic [31:0] msg_words[64];
  logic [31:0] din_log[$], res_log[$];
  logic last_log[$];
  int din_cyc[$], dout_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // bus monitor: logs every transfer and watches handshake rules
  always @(posedge clk) begin
    cyc++;
    if (din_valid && din_ready) begin
      din_log.push_back(din);
      din_cyc.push_back(cyc);
    end
    if (res_valid && res_ready) begin
      res_log.push_back(res_data);
      last_log.push_back(res_last);
    end
    if (dout_valid && dout_ready) dout_cyc.push_back(cyc);
    if (msg_ready) msg_rdy_cnt++;
    if (force_done) force_cnt++;
    if (err && req_ready) rr_viol++;
    if (pend && (!din_valid || din !== pend_din)) stab_viol++;
    pend = din_valid && !din_ready && !abort && !rst;
    pend_din = din;
  end

  // host message source, keccak digest source and din_ready pattern
  initial begin
    logic mh, dh;
    forever begin
      @(posedge clk);
      mh = msg_valid && msg_ready;
      dh = dout_valid && dout_ready;
      #1;
      if (mh) msg_idx++;
      if (dh) dout_idx++;
      msg_data = msg_words[(msg_idx - msg_start) & 63];
      dout = 32'hD000_0000 + 32'(dout_idx);
      din_ready = toggle ? !din_ready : 1'b1;
    end
  end

  task automatic start_req(input logic m, input logic [15:0] ol, input logic [15:0] il, input int tag);
    int t;
    for (int k = 0; k < 64; k++) msg_words[k] = 32'hA500_0000 + 32'(tag) * 256 + 32'(k);
    msg_start = msg_idx;
    dout_base = dout_idx;
    din_start = din_log.size();
    res_start = res_log.size();
    dout_start = dout_cyc.size();
    msg_rdy0 = msg_rdy_cnt;
    for (t = 0; t < 50 && !req_ready; t++) @(negedge clk);
    check("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_mode = m;
    req_outlen = ol;
    req_inlen = il;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic finish_chk(input logic [31:0] hdr, input logic [31:0] len, input int nin, input int nout, input logic e);
    int t;
    fall_cyc = -1;
    for (t = 0; t < 2000 && (busy || res_valid); t++) begin
      @(negedge clk);
      if (!busy && fall_cyc < 0) fall_cyc = cyc;
    end
    check("done_timeout", busy || res_valid, 0);
    repeat (2) @(negedge clk);
    if (e) check("rejected_din_count", din_log.size() - din_start, 0);
    else begin
      check("din_count", din_log.size() - din_start, 2 + nin);
      check("res_count", res_log.size() - res_start, nout);
      check("msg_ready_cycles", msg_rdy_cnt - msg_rdy0, nin);
      if (din_log.size() >= din_start + 2) begin
        check("din_hdr", din_log[din_start], hdr);
        check("din_len", din_log[din_start + 1], len);
      end
      for (int k = 0; k < nin && din_start + 2 + k < din_log.size(); k++)
        check("din_data", din_log[din_start + 2 + k], msg_words[k]);
      for (int j = 0; j < nout && res_start + j < res_log.size(); j++) begin
        check("res_data", res_log[res_start + j], 32'hD000_0000 + 32'(dout_base + j));
        check("res_last", last_log[res_start + j], j == nout - 1);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    start_req(v.mode, v.outlen, v.inlen, tag);
    check("err_pulse", err, v.err);
    check("busy_after_req", busy, !v.err);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    finish_chk(v.hdr, v.len, v.nin, v.nout, v.err);
  endtask

  initial begin
    int t;
    vecs[0] = '{1'b0, 16'd512, 16'd32,   32'h0000_0200, 32'h8000_0020, 1,  16, 1'b0};
    vecs[1] = '{1'b1, 16'd512, 16'd64,   32'h4000_0200, 32'h8000_0040, 2,  16, 1'b0};
    vecs[2] = '{1'b0, 16'd32,  16'd0,    32'h0000_0020, 32'h8000_0000, 0,  1,  1'b0};
    vecs[3] = '{1'b1, 16'd100, 16'd40,   32'h4000_0064, 32'h8000_0028, 2,  4,  1'b0};
    vecs[4] = '{1'b0, 16'd0,   16'd32,   32'h0,         32'h0,         0,  0,  1'b1};
    vecs[5] = '{1'b0, 16'd256, 16'd1056, 32'h0,         32'h0,         0,  0,  1'b1};
    vecs[6] = '{1'b1, 16'd256, 16'd1024, 32'h4000_0100, 32'h8000_0400, 32, 8,  1'b0};

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_outputs", {busy, din_valid, msg_ready, dout_ready, force_done, res_valid, res_last, err}, 0);
    check("rst_din", din, 0);
    check("rst_res_data", res_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      if (i == 0) begin
        check("hdr_len_consecutive", din_cyc[din_start + 1] - din_cyc[din_start], 1);
        check("len_data_consecutive", din_cyc[din_start + 2] - din_cyc[din_start + 1], 1);
        check("busy_fall_at_last_dout", fall_cyc, dout_cyc[dout_start + 15]);
      end
    end

    toggle = 1'b1;
    run_vec('{1'b1, 16'd512, 16'd64, 32'h4000_0200, 32'h8000_0040, 2, 16, 1'b0}, 10);
    toggle = 1'b0;
    check("din_stable_when_stalled", stab_viol, 0);

    res_ready = 1'b0;
    start_req(1'b0, 16'd256, 16'd32, 11);
    check("hold_err", err, 0);
    for (t = 0; t < 100 && !res_valid; t++) @(negedge clk);
    check("hold_res_valid_wait", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("hold_dout_ready", dout_ready, 0);
      check("hold_res_valid", res_valid, 1);
      check("hold_res_data", res_data, 32'hD000_0000 + 32'(dout_base));
      @(negedge clk);
    end
    res_ready = 1'b1;
    finish_chk(32'h0000_0100, 32'h8000_0020, 1, 8, 1'b0);

    force0 = force_cnt;
    start_req(1'b0, 16'd256, 16'd96, 12);
    for (t = 0; t < 50 && din_log.size() < din_start + 3; t++) @(negedge clk);
    check("abort_first_word", din_log.size() >= din_start + 3, 1);
    check("abort_word0", din_log[din_start + 2], msg_words[0]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_force_done", force_done, 1);
    check("abort_busy_held", busy, 1);
    check("abort_res_valid", res_valid, 0);
    @(negedge clk);
    check("abort_force_done_clear", force_done, 0);
    check("abort_busy_clear", busy, 0);
    check("abort_req_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    check("abort_force_once", force_cnt - force0, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ignored", {busy, force_done}, 0);
    run_vec(vecs[0], 13);

    start_req(1'b1, 16'd512, 16'd32, 14);
    for (t = 0; t < 100 && !res_valid; t++) @(negedge clk);
    check("rst_resp_wait", res_valid, 1);
    force0 = force_cnt;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_req_ready", req_ready, 0);
    check("midrst_outputs", {busy, din_valid, msg_ready, dout_ready, force_done, res_valid, res_last, err}, 0);
    check("midrst_din", din, 0);
    check("midrst_res_data", res_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", {req_ready, busy}, 2'b10);
    check("midrst_no_force", force_cnt - force0, 0);
    check("err_req_ready_overlap", rr_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
